// File: rtl/thor2021_irq_acceptor_if.sv
// Signal bundle between the PIC/pipeline environment and the Thor2021 interrupt acceptor.
// The acceptor connects through the slave modport.
interface thor2021_irq_acceptor_if;
  logic [3:0] irq_i;
  logic [7:0] cause_i;
  logic       nmi_i;
  logic       bnd_i;
  logic       take_i;
  logic       rti_i;
  logic       im_wr_i;
  logic [3:0] im_dat_i;
  logic       req_o;
  logic [3:0] req_level_o;
  logic [7:0] req_cause_o;
  logic       req_nmi_o;
  logic [3:0] im_o;
  logic [4:0] depth_o;
  logic       ovf_o;

  modport master (
    output irq_i, cause_i, nmi_i, bnd_i, take_i, rti_i, im_wr_i, im_dat_i,
    input  req_o, req_level_o, req_cause_o, req_nmi_o, im_o, depth_o, ovf_o
  );

  modport slave (
    input  irq_i, cause_i, nmi_i, bnd_i, take_i, rti_i, im_wr_i, im_dat_i,
    output req_o, req_level_o, req_cause_o, req_nmi_o, im_o, depth_o, ovf_o
  );
endinterface

// File: rtl/thor2021_irq_acceptor.sv
// CPU-side interrupt acceptor: filters and qualifies PIC requests, presents one request at an
// instruction boundary, and keeps a stack of prior mask levels for nested handlers.
module thor2021_irq_acceptor #(
  parameter int         pDepth    = 8,
  parameter logic [7:0] pNmiCause = 8'hFE
) (
  input logic                     clk_i,
  input logic                     rst_i,
  thor2021_irq_acceptor_if.slave  bus
);

  localparam int AW = $clog2(pDepth);

  typedef enum logic [1:0] {IDLE, PEND, REQ} state_t;

  state_t     state, state_nxt;
  logic       capture;

  logic [3:0] irq_p0;
  logic [7:0] cause_p0;
  logic       stab_p1;
  logic       nmi_prev, nmi_pend;

  logic [3:0] lvl_q;
  logic [7:0] cause_q;
  logic       nmi_q;

  logic [3:0] im;
  logic [4:0] depth;
  logic       ovf;
  logic       rti_def;
  logic [3:0] stk [pDepth];

  logic          full, empty, elig, keep, take_fire, pop_req;
  logic [AW-1:0] wr_idx, top_idx;

  assign full      = (depth == 5'(pDepth));
  assign empty     = (depth == 5'd0);
  assign elig      = stab_p1 && (irq_p0 != 4'd0) && (irq_p0 > im) && !full;
  assign keep      = nmi_q || (elig && (irq_p0 == lvl_q));
  assign take_fire = (state == REQ) && bus.take_i;
  assign pop_req   = bus.rti_i || rti_def;
  assign wr_idx    = depth[AW-1:0];
  assign top_idx   = AW'(depth - 5'd1);

  // Stage p0/p1: two matching samples of irq/cause make the filtered request valid
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      irq_p0   <= '0;
      cause_p0 <= '0;
      stab_p1  <= 1'b0;
      nmi_prev <= 1'b0;
      nmi_pend <= 1'b0;
    end else begin
      irq_p0   <= bus.irq_i;
      cause_p0 <= bus.cause_i;
      stab_p1  <= (bus.irq_i == irq_p0) && (bus.cause_i == cause_p0);
      nmi_prev <= bus.nmi_i;
      // A fresh edge wins over the clear so an NMI arriving at take time is not lost
      if (bus.nmi_i && !nmi_prev)
        nmi_pend <= 1'b1;
      else if (take_fire && nmi_q)
        nmi_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: if (nmi_pend || elig) begin
        capture   = 1'b1;
        state_nxt = PEND;
      end
      PEND: begin
        if (!keep)          state_nxt = IDLE;
        else if (bus.bnd_i) state_nxt = REQ;
      end
      REQ:     if (bus.take_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Captured request is frozen from capture until the take
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lvl_q   <= '0;
      cause_q <= '0;
      nmi_q   <= 1'b0;
    end else if (capture) begin
      if (nmi_pend) begin
        lvl_q   <= 4'hF;
        cause_q <= pNmiCause;
        nmi_q   <= 1'b1;
      end else begin
        lvl_q   <= irq_p0;
        cause_q <= cause_p0;
        nmi_q   <= 1'b0;
      end
    end
  end

  // A take and an RTI in the same cycle: the take wins and the pop is deferred one cycle
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      im      <= 4'hF;
      depth   <= '0;
      ovf     <= 1'b0;
      rti_def <= 1'b0;
    end else if (take_fire) begin
      rti_def <= bus.rti_i;
      im      <= lvl_q;
      if (full) ovf   <= 1'b1;
      else      depth <= depth + 5'd1;
    end else begin
      rti_def <= rti_def && bus.rti_i;
      if (bus.im_wr_i) im <= bus.im_dat_i;
      if (pop_req) begin
        if (empty) begin
          ovf <= 1'b1;
        end else begin
          depth <= depth - 5'd1;
          if (!bus.im_wr_i) im <= stk[top_idx];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (take_fire && !full) stk[wr_idx] <= im;
  end

  assign bus.req_o       = (state == REQ);
  assign bus.req_level_o = lvl_q;
  assign bus.req_cause_o = cause_q;
  assign bus.req_nmi_o   = nmi_q;
  assign bus.im_o        = im;
  assign bus.depth_o     = depth;
  assign bus.ovf_o       = ovf;

endmodule

// File: tb/tb_thor2021_irq_acceptor.sv
// Bench for thor2021_irq_acceptor: directed scenarios with literal expectations plus a long
// randomized run compared every cycle against a transaction-level model of the acceptor.
module tb_thor2021_irq_acceptor;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  thor2021_irq_acceptor_if bus();

  thor2021_irq_acceptor #(.pDepth(DEPTH), .pNmiCause(8'hFE)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: request lifecycle 0 = none, 1 = captured, 2 = presented
  int         m_im = 15, m_ovf = 0, m_phase = 0, m_pend_pops = 0;
  int         m_cap_lvl = 0, m_cap_cause = 0;
  bit         m_cap_nmi = 0, m_nmi_pend = 0, m_nmi_last = 0;
  int         m_stack[$];
  logic [11:0] m_s[$];

  always @(posedge clk or negedge rst_n) begin : model
    bit filt, ok, fired, edge_seen;
    int flvl, im0, d0, ph, t;
    if (!rst_n) begin
      m_im = 15; m_ovf = 0; m_phase = 0; m_pend_pops = 0;
      m_cap_lvl = 0; m_cap_cause = 0; m_cap_nmi = 0;
      m_nmi_pend = 0; m_nmi_last = 0;
      m_stack.delete(); m_s.delete();
    end else begin
      im0  = m_im;
      d0   = m_stack.size();
      ph   = m_phase;
      filt = (m_s.size() >= 2) && (m_s[m_s.size()-1] == m_s[m_s.size()-2]);
      flvl = filt ? int'(m_s[m_s.size()-1][11:8]) : 0;
      ok   = filt && flvl != 0 && flvl > im0 && d0 < DEPTH;
      edge_seen = bus.nmi_i && !m_nmi_last;
      fired = (ph == 2) && bus.take_i;
      m_pend_pops += int'(bus.rti_i);
      if (fired) begin
        if (d0 == DEPTH) m_ovf = 1;
        else             m_stack.push_back(im0);
        m_im = m_cap_lvl;
        ph = 0;
      end else begin
        if (bus.im_wr_i) m_im = int'(bus.im_dat_i);
        if (m_pend_pops > 0) begin
          m_pend_pops--;
          if (m_stack.size() == 0) m_ovf = 1;
          else begin
            t = m_stack.pop_back();
            if (!bus.im_wr_i) m_im = t;
          end
        end
        if (ph == 1) begin
          if (!(m_cap_nmi || (ok && flvl == m_cap_lvl))) ph = 0;
          else if (bus.bnd_i) ph = 2;
        end else if (ph == 0 && (m_nmi_pend || ok)) begin
          if (m_nmi_pend) begin
            m_cap_lvl = 15; m_cap_cause = 'hFE; m_cap_nmi = 1;
          end else begin
            m_cap_lvl = flvl; m_cap_cause = int'(m_s[m_s.size()-1][7:0]); m_cap_nmi = 0;
          end
          ph = 1;
        end
      end
      if (edge_seen)                 m_nmi_pend = 1;
      else if (fired && m_cap_nmi)   m_nmi_pend = 0;
      m_phase = ph;
      m_nmi_last = bus.nmi_i;
      m_s.push_back({bus.irq_i, bus.cause_i});
      if (m_s.size() > 2) void'(m_s.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_req", int'(bus.req_o), int'(m_phase == 2));
      if (m_phase == 2) begin
        chk("m_level", int'(bus.req_level_o), m_cap_lvl);
        chk("m_cause", int'(bus.req_cause_o), m_cap_cause);
        chk("m_nmi",   int'(bus.req_nmi_o),   int'(m_cap_nmi));
      end
      chk("m_im",    int'(bus.im_o),    m_im);
      chk("m_depth", int'(bus.depth_o), m_stack.size());
      chk("m_ovf",   int'(bus.ovf_o),   m_ovf);
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_req(input string nm, input int max);
    int k = 0;
    while (!bus.req_o && k < max) begin
      cyc();
      k++;
    end
    chk(nm, int'(bus.req_o), 1);
  endtask

  task automatic take_one();
    bus.take_i = 1'b1; cyc(); bus.take_i = 1'b0;
  endtask

  task automatic rti_one();
    bus.rti_i = 1'b1; cyc(); bus.rti_i = 1'b0;
  endtask

  task automatic set_im(input logic [3:0] v);
    bus.im_wr_i = 1'b1; bus.im_dat_i = v; cyc(); bus.im_wr_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int lv[3];
    int ime[3];
    lv  = '{2, 5, 9};
    ime = '{5, 2, 0};
    bus.irq_i = '0; bus.cause_i = '0; bus.nmi_i = 1'b0; bus.bnd_i = 1'b1;
    bus.take_i = 1'b0; bus.rti_i = 1'b0; bus.im_wr_i = 1'b0; bus.im_dat_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_req",   int'(bus.req_o),   0);
    chk("rst_im",    int'(bus.im_o),    15);
    chk("rst_depth", int'(bus.depth_o), 0);
    chk("rst_ovf",   int'(bus.ovf_o),   0);
    rst_n = 1'b1;
    cyc();

    // Basic request: four cycles from a stable eligible level to req_o
    set_im(4'd3);
    chk("t1_im", int'(bus.im_o), 3);
    bus.irq_i = 4'd5; bus.cause_i = 8'h21;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk("t1_latency", int'(bus.req_o), int'(k == 4));
    end
    chk("t1_level", int'(bus.req_level_o), 5);
    chk("t1_cause", int'(bus.req_cause_o), 'h21);
    take_one();
    bus.irq_i = '0;
    chk("t1_req_off", int'(bus.req_o), 0);
    chk("t1_im_take", int'(bus.im_o), 5);
    chk("t1_depth",   int'(bus.depth_o), 1);
    rti_one();
    chk("t1_im_rti", int'(bus.im_o), 3);

    // Levels at or below the mask never request
    set_im(4'd6);
    bus.irq_i = 4'd4; bus.cause_i = 8'h10;
    for (int k = 0; k < 20; k++) begin
      cyc();
      chk("t2_masked", int'(bus.req_o), 0);
    end
    bus.irq_i = 4'd7; bus.cause_i = 8'h11;
    wait_req("t2_req", 8);
    chk("t2_level", int'(bus.req_level_o), 7);
    take_one();
    bus.irq_i = '0;
    chk("t2_im", int'(bus.im_o), 7);
    rti_one();
    chk("t2_im_rti", int'(bus.im_o), 6);

    // Unstable level never passes the filter
    set_im(4'd0);
    for (int k = 0; k < 16; k++) begin
      bus.irq_i = (k % 2 == 1) ? 4'd6 : 4'd5;
      cyc();
      chk("t5_unstable", int'(bus.req_o), 0);
    end
    bus.irq_i = 4'd6;
    wait_req("t5_req", 8);
    chk("t5_level", int'(bus.req_level_o), 6);
    take_one();
    bus.irq_i = '0;
    rti_one();
    chk("t5_im", int'(bus.im_o), 0);

    // Nesting three takes then unwinding, plus an underflow RTI
    for (int n = 0; n < 3; n++) begin
      bus.irq_i = 4'(lv[n]); bus.cause_i = 8'(lv[n] + 'h40);
      wait_req("t4_req", 8);
      chk("t4_level", int'(bus.req_level_o), lv[n]);
      take_one();
      bus.irq_i = '0;
      chk("t4_im_push", int'(bus.im_o), lv[n]);
      chk("t4_depth_push", int'(bus.depth_o), n + 1);
    end
    for (int n = 0; n < 3; n++) begin
      rti_one();
      chk("t4_im_pop", int'(bus.im_o), ime[n]);
      chk("t4_depth_pop", int'(bus.depth_o), 2 - n);
    end
    rti_one();
    chk("t4_ovf", int'(bus.ovf_o), 1);
    chk("t4_im_under", int'(bus.im_o), 0);

    // NMI bypasses a fully closed mask; a second edge before the take gives no extra request
    bus.bnd_i = 1'b0;
    set_im(4'hF);
    bus.irq_i = 4'd9; bus.cause_i = 8'h33;
    bus.nmi_i = 1'b1; cyc(); bus.nmi_i = 1'b0; cyc(); cyc();
    bus.nmi_i = 1'b1; cyc(); bus.nmi_i = 1'b0; cyc();
    chk("t3_held", int'(bus.req_o), 0);
    bus.bnd_i = 1'b1;
    wait_req("t3_req", 4);
    chk("t3_nmi",   int'(bus.req_nmi_o),   1);
    chk("t3_cause", int'(bus.req_cause_o), 'hFE);
    chk("t3_level", int'(bus.req_level_o), 15);
    take_one();
    chk("t3_im", int'(bus.im_o), 15);
    chk("t3_depth", int'(bus.depth_o), 1);
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("t3_single", int'(bus.req_o), 0);
    end
    rti_one();
    bus.irq_i = '0;

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 15) begin
        bus.irq_i   = 4'($urandom_range(0, 15));
        bus.cause_i = 8'($urandom_range(0, 255));
      end
      bus.bnd_i    = ($urandom_range(0, 99) < 70);
      bus.take_i   = ($urandom_range(0, 99) < 30);
      bus.rti_i    = ($urandom_range(0, 99) < 6);
      bus.im_wr_i  = ($urandom_range(0, 99) < 4);
      bus.im_dat_i = 4'($urandom_range(0, 15));
      bus.nmi_i    = ($urandom_range(0, 99) < 3);
      cyc();
    end

    // Asynchronous reset while a request is presented and an NMI is latched
    bus.irq_i = '0; bus.bnd_i = 1'b1; bus.take_i = 1'b0; bus.rti_i = 1'b0;
    bus.im_wr_i = 1'b0; bus.nmi_i = 1'b0;
    cyc();
    bus.nmi_i = 1'b1; cyc(); bus.nmi_i = 1'b0;
    wait_req("t6_req", 8);
    bus.nmi_i = 1'b1; cyc(); bus.nmi_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_req",   int'(bus.req_o),       0);
    chk("t6_im",    int'(bus.im_o),        15);
    chk("t6_depth", int'(bus.depth_o),     0);
    chk("t6_ovf",   int'(bus.ovf_o),       0);
    chk("t6_level", int'(bus.req_level_o), 0);
    chk("t6_nmi",   int'(bus.req_nmi_o),   0);
    @(negedge clk);
    cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("t6_latch_clear", int'(bus.req_o), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/thor2021_irq_acceptor.md
Name: thor2021_irq_acceptor

Overview:
CPU-side receiver for the interrupt controller's irqo[3:0] / causeo[7:0] / nmio outputs.
- Qualifies requests against the current interrupt mask level.
- Presents one stable request (level, cause, NMI flag) to the pipeline at an instruction boundary and completes a take handshake.
- Maintains a nesting stack of prior mask levels, restored on return-from-interrupt.
- Sits between the PIC outputs and the Thor2021 exception/commit logic.

Parameters:
pDepth, 8, number of entries in the mask-level nesting stack (power of 2, 2..16)
pNmiCause, 8'hFE, cause code reported for an NMI

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset, asynchronous, active-low
irq_i  in  4  interrupt level from the controller; 0 = none
cause_i  in  8  cause code from the controller
nmi_i  in  1  NMI level from the controller
bnd_i  in  1  pipeline is at an instruction boundary and may accept an interrupt
take_i  in  1  pipeline accepts the presented request this cycle
rti_i  in  1  return-from-interrupt commits; pop the mask stack
im_wr_i  in  1  software write of the mask level
im_dat_i  in  4  mask level to write
req_o  out  1  interrupt request to the pipeline
req_level_o  out  4  level of the presented request
req_cause_o  out  8  cause of the presented request
req_nmi_o  out  1  the presented request is an NMI
im_o  out  4  current mask level
depth_o  out  5  current stack occupancy, 0..pDepth
ovf_o  out  1  sticky: a take or RTI was attempted at a stack limit

Behaviour:
Reset (rst_i low, async):
- req_o = 0, req_level_o = 0, req_cause_o = 0, req_nmi_o = 0.
- im_o = 4'hF (all maskable interrupts blocked), depth_o = 0, ovf_o = 0.
- NMI latch and edge register cleared; state = IDLE.

NMI path:
- nmi_prev registered each cycle.
- Rising edge (nmi_i & !nmi_prev) sets nmi_pend.
- nmi_pend is cleared only when an NMI is taken.
- NMI ignores im_o.

Maskable qualification:
- Eligible when irq_i != 0, irq_i > im_o, and depth_o < pDepth.
- irq_i and cause_i must hold the same value for 2 consecutive cycles (stable filter). Any change restarts the filter.

FSM states: IDLE, PEND, REQ.
- IDLE -> PEND when nmi_pend is set or a maskable request is eligible.
  - Capture level/cause; NMI has priority and is captured as level 4'hF, cause pNmiCause.
- PEND -> REQ when bnd_i = 1; req_o rises the following cycle.
- PEND -> IDLE if the captured source drops or is no longer eligible before bnd_i (maskable only; a captured NMI never drops).
- REQ holds req_o and all req_* outputs stable until take_i.
- REQ, take_i = 1:
  - Push im_o onto the stack; depth +1.
  - im_o <= req_level_o.
  - If NMI, clear nmi_pend.
  - Go to IDLE; req_o = 0 the next cycle.
- REQ, no take_i, and the source withdrawn (maskable only):
  - Request stays presented; the controller's cause is captured.
  - The handler reads the PIC to confirm. No retraction once req_o = 1.
- Minimum latency from a stable eligible irq_i (with bnd_i held high) to req_o = 4 cycles: 2 filter, 1 capture, 1 present.

Stack:
- rti_i pops: im_o <= top; depth -1.
- rti_i at depth 0: no change, ovf_o <= 1.
- NMI take at depth pDepth: push suppressed, im_o <= 4'hF, ovf_o <= 1.

Simultaneous events:
- take_i and rti_i in the same cycle: take wins; the RTI pop is applied on the next cycle.
- take_i has priority over im_wr_i.
- im_wr_i has priority over rti_i.
- im_wr_i does not touch the stack.
- A new NMI edge while a maskable request is in REQ:
  - The maskable request completes first.
  - The NMI is presented on the next pass; it is latched and never lost.

Widths:
- Level comparison is unsigned 4-bit.
- depth_o saturates at pDepth and at 0.

Test Plan:
1. im_wr_i = 1, im_dat_i = 3; irq_i = 5, cause_i = 8'h21 held; bnd_i = 1 -> req_o = 1 on cycle 4 with req_level_o = 5, req_cause_o = 8'h21; take_i -> im_o = 5, depth_o = 1, req_o = 0 next cycle.
2. im_o = 6; irq_i = 4 held for 20 cycles -> req_o stays 0. Then irq_i = 7 -> request presented with level 7.
3. Single-cycle pulse on nmi_i while im_o = 4'hF and irq_i = 9 -> req_nmi_o = 1, req_cause_o = 8'hFE, req_level_o = 15; take_i -> im_o = 15; a second pulse before the take gives only one request.
4. Nest 3 takes (levels 2, 5, 9 from base im_o = 0), then 3× rti_i -> im_o sequence 5, 2, 0; depth_o 3 -> 0; a 4th rti_i -> ovf_o = 1 and im_o stays 0.
5. irq_i alternating between 5 and 6 every cycle -> req_o never asserts. Then held at 6 -> req_o asserts.
6. Assert rst_i low while in REQ -> req_o = 0 immediately (async); im_o = 15, depth_o = 0, ovf_o = 0; the NMI latch is cleared.
